// File: rtl/ib_mul_pkg.sv
// rtl/ib_mul_pkg.sv - shared constants, FSM encoding and helpers for the ib_mul sweeper
package ib_mul_pkg;

    localparam int IB_W      = 8;
    localparam int IB_W2     = 2 * IB_W;
    localparam int IB_SETTLE = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_APPLY = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } sweep_state_t;

    // WAIT must cover both the multiplier settle time and the reference latency.
    function automatic int wait_cycles(input int settle, input int w);
        return (settle > w) ? settle : w;
    endfunction

endpackage

// File: rtl/ib_mul_ref_seq.sv
// rtl/ib_mul_ref_seq.sv - sequential shift-add reference multiplier, W cycles per product
module ib_mul_ref_seq
    import ib_mul_pkg::*;
#(
    parameter int W = IB_W
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_load,
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    output logic [2*W-1:0]   o_p,
    output logic             o_done
);

    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // The load cycle already consumes multiplier bit 0, so W-1 further steps follow.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (i_load) begin
            acc_d    = i_b[0] ? {{W{1'b0}}, i_a} : '0;
            mcand_d  = {{(W-1){1'b0}}, i_a, 1'b0};
            mplier_d = i_b >> 1;
            cnt_d    = CW'(W - 1);
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_p    = acc_q;
    assign o_done = (cnt_q == '0);

endmodule

// File: rtl/ib_mul_sweep.sv
// rtl/ib_mul_sweep.sv - exhaustive operand sweeper and product checker for ib_mul multipliers
module ib_mul_sweep
    import ib_mul_pkg::*;
#(
    parameter int W      = IB_W,
    parameter int SETTLE = IB_SETTLE
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_start,
    output logic [W-1:0]     o_a,
    output logic [W-1:0]     o_b,
    input  logic [2*W-1:0]   i_c,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [W-1:0]     o_fail_a,
    output logic [W-1:0]     o_fail_b,
    output logic [2*W-1:0]   o_fail_c
);

    localparam int W2 = 2 * W;
    localparam int M  = wait_cycles(SETTLE, W);
    localparam int SW = (M > 1) ? $clog2(M) : 1;

    sweep_state_t state_q, state_d;

    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [W-1:0]  oa_q, oa_d, ob_q, ob_d;
    logic [W-1:0]  fa_q, fa_d, fb_q, fb_d;
    logic [W2-1:0] c_q, c_d, fc_q, fc_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          pass_q, pass_d;

    logic [W2-1:0] ref_p;
    logic          ref_done;
    logic          ref_load;
    logic          sample;
    logic          clear;
    logic          wait_exit;
    logic          mismatch;
    logic          last_pair;

    ib_mul_ref_seq #(.W(W)) u_ref (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_load (ref_load),
        .i_a    (a_q),
        .i_b    (b_q),
        .o_p    (ref_p),
        .o_done (ref_done)
    );

    assign wait_exit = (cnt_q == '0) && ref_done;
    assign mismatch  = (c_q != ref_p);
    assign last_pair = (&a_q) && (&b_q);

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (i_start) state_d = ST_APPLY;
            ST_APPLY:         state_d = ST_WAIT;
            ST_WAIT:          if (wait_exit) state_d = ST_CHECK;
            ST_CHECK:         state_d = (mismatch || last_pair) ? ST_DONE : ST_APPLY;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy   = 1'b0;
        o_done   = 1'b0;
        ref_load = 1'b0;
        sample   = 1'b0;
        clear    = 1'b0;
        unique case (state_q)
            ST_IDLE:  clear = i_start;
            ST_APPLY: begin o_busy = 1'b1; ref_load = 1'b1; end
            ST_WAIT:  begin o_busy = 1'b1; sample = wait_exit; end
            ST_CHECK: o_busy = 1'b1;
            ST_DONE:  begin o_done = 1'b1; clear = i_start; end
            default:  ;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        oa_d   = oa_q;
        ob_d   = ob_q;
        fa_d   = fa_q;
        fb_d   = fb_q;
        fc_d   = fc_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        pass_d = pass_q;
        if (clear) begin
            a_d    = '0;
            b_d    = '0;
            fa_d   = '0;
            fb_d   = '0;
            fc_d   = '0;
            pass_d = 1'b0;
        end
        if (state_q == ST_APPLY) begin
            oa_d  = a_q;
            ob_d  = b_q;
            cnt_d = SW'(M - 1);
        end
        if (state_q == ST_WAIT && cnt_q != '0) begin
            cnt_d = cnt_q - SW'(1);
        end
        if (sample) begin
            c_d = i_c;
        end
        // B is the inner loop; A advances only when B wraps.
        if (state_q == ST_CHECK) begin
            if (mismatch) begin
                fa_d   = a_q;
                fb_d   = b_q;
                fc_d   = c_q;
                pass_d = 1'b0;
            end else if (last_pair) begin
                pass_d = 1'b1;
            end else begin
                b_d = b_q + W'(1);
                if (&b_q) begin
                    a_d = a_q + W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            a_q    <= '0;
            b_q    <= '0;
            oa_q   <= '0;
            ob_q   <= '0;
            fa_q   <= '0;
            fb_q   <= '0;
            fc_q   <= '0;
            c_q    <= '0;
            cnt_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            oa_q   <= oa_d;
            ob_q   <= ob_d;
            fa_q   <= fa_d;
            fb_q   <= fb_d;
            fc_q   <= fc_d;
            c_q    <= c_d;
            cnt_q  <= cnt_d;
            pass_q <= pass_d;
        end
    end

    assign o_a      = oa_q;
    assign o_b      = ob_q;
    assign o_pass   = pass_q;
    assign o_fail_a = fa_q;
    assign o_fail_b = fb_q;
    assign o_fail_c = fc_q;

endmodule

// File: tb/tb_ib_mul_sweep.sv
// tb/tb_ib_mul_sweep.sv - directed self-checking bench for ib_mul_sweep
module tb_ib_mul_sweep;

    logic clk;
    int   n_checks = 0;
    int   n_errors = 0;

    // d8: W=8 SETTLE=2, multiplier with bit 0 inverted at A=3 B=5
    logic        nrst8, start8, busy8, done8, pass8;
    logic [7:0]  a8, b8, fa8, fb8;
    logic [15:0] c8, fc8;
    // d4: W=4 SETTLE=2, model selected by mode4 (0 good, 1 last-pair fault, 2 delayed)
    logic        nrst4, start4, busy4, done4, pass4;
    logic [3:0]  a4, b4, fa4, fb4;
    logic [7:0]  c4, fc4;
    int          mode4;
    // d12: W=4 SETTLE=12, good multiplier
    logic        nrst12, start12, busy12, done12, pass12;
    logic [3:0]  a12, b12, fa12, fb12;
    logic [7:0]  c12, fc12;
    // d20: W=4 SETTLE=20, delayed multiplier
    logic        nrst20, start20, busy20, done20, pass20;
    logic [3:0]  a20, b20, fa20, fb20;
    logic [7:0]  c20, fc20;

    logic [7:0]  dl4  [19];
    logic [7:0]  dl20 [19];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ib_mul_sweep #(.W(8), .SETTLE(2)) d8 (
        .i_clk(clk), .i_nrst(nrst8), .i_start(start8), .o_a(a8), .o_b(b8), .i_c(c8),
        .o_busy(busy8), .o_done(done8), .o_pass(pass8),
        .o_fail_a(fa8), .o_fail_b(fb8), .o_fail_c(fc8));

    ib_mul_sweep #(.W(4), .SETTLE(2)) d4 (
        .i_clk(clk), .i_nrst(nrst4), .i_start(start4), .o_a(a4), .o_b(b4), .i_c(c4),
        .o_busy(busy4), .o_done(done4), .o_pass(pass4),
        .o_fail_a(fa4), .o_fail_b(fb4), .o_fail_c(fc4));

    ib_mul_sweep #(.W(4), .SETTLE(12)) d12 (
        .i_clk(clk), .i_nrst(nrst12), .i_start(start12), .o_a(a12), .o_b(b12), .i_c(c12),
        .o_busy(busy12), .o_done(done12), .o_pass(pass12),
        .o_fail_a(fa12), .o_fail_b(fb12), .o_fail_c(fc12));

    ib_mul_sweep #(.W(4), .SETTLE(20)) d20 (
        .i_clk(clk), .i_nrst(nrst20), .i_start(start20), .o_a(a20), .o_b(b20), .i_c(c20),
        .o_busy(busy20), .o_done(done20), .o_pass(pass20),
        .o_fail_a(fa20), .o_fail_b(fb20), .o_fail_c(fc20));

    assign c8  = (16'(a8) * 16'(b8)) ^ ((a8 == 8'd3 && b8 == 8'd5) ? 16'd1 : 16'd0);
    assign c12 = 8'(a12) * 8'(b12);
    assign c20 = dl20[18];

    always_comb begin
        c4 = 8'(a4) * 8'(b4);
        if (mode4 == 1 && a4 == 4'hf && b4 == 4'hf) c4 = 8'd0;
        else if (mode4 == 2) c4 = dl4[18];
    end

    // Operands change at edge E; the delayed product is visible after edge E+19.
    always @(posedge clk) begin
        if (!nrst4) begin
            for (int i = 0; i < 19; i++) dl4[i] <= 8'd0;
        end else begin
            dl4[0] <= 8'(a4) * 8'(b4);
            for (int i = 1; i < 19; i++) dl4[i] <= dl4[i-1];
        end
    end

    always @(posedge clk) begin
        if (!nrst20) begin
            for (int j = 0; j < 19; j++) dl20[j] <= 8'd0;
        end else begin
            dl20[0] <= 8'(a20) * 8'(b20);
            for (int j = 1; j < 19; j++) dl20[j] <= dl20[j-1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       start8  = v;
            1:       start4  = v;
            2:       start12 = v;
            default: start20 = v;
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return done8;
            1:       return done4;
            2:       return done12;
            default: return done20;
        endcase
    endfunction

    task automatic kick(input int sel);
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
    endtask

    // cycles counts rising edges, the edge that samples the start being 1.
    task automatic wait_done(input int sel, input int hold_from, input int hold_len,
                             input int budget, input int cyc0, output int cycles);
        cycles = cyc0;
        while (!get_done(sel) && cycles < budget) begin
            set_start(sel, (cycles >= hold_from) && (cycles < hold_from + hold_len));
            @(posedge clk); #1;
            cycles++;
        end
        set_start(sel, 1'b0);
        if (!get_done(sel)) chk("timeout", 32'(get_done(sel)), 32'd1);
    endtask

    initial begin
        int cyc;
        int prev_b;
        int nchg;
        int tch [3];

        nrst8 = 1'b0; nrst4 = 1'b0; nrst12 = 1'b0; nrst20 = 1'b0;
        start8 = 1'b0; start4 = 1'b0; start12 = 1'b0; start20 = 1'b0;
        mode4 = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_pass", 32'(pass4), 32'd0);
        chk("rst_a", 32'(a4), 32'd0);
        chk("rst_fc", 32'(fc4), 32'd0);
        nrst8 = 1'b1; nrst4 = 1'b1; nrst12 = 1'b1; nrst20 = 1'b1;
        @(posedge clk); #1;

        // early single-bit fault on the W=8 sweeper
        kick(0);
        chk("start_busy", 32'(busy8), 32'd1);
        wait_done(0, 0, 0, 20000, 1, cyc);
        chk("early_lat", cyc, 32'd7741);
        chk("early_pass", 32'(pass8), 32'd0);
        chk("early_fa", 32'(fa8), 32'd3);
        chk("early_fb", 32'(fb8), 32'd5);
        chk("early_fc", 32'(fc8), 32'd14);
        chk("early_busy", 32'(busy8), 32'd0);

        // last-pair fault
        kick(1);
        wait_done(1, 0, 0, 5000, 1, cyc);
        chk("last_lat", cyc, 32'd1537);
        chk("last_pass", 32'(pass4), 32'd0);
        chk("last_fa", 32'(fa4), 32'd15);
        chk("last_fb", 32'(fb4), 32'd15);
        chk("last_fc", 32'(fc4), 32'd0);

        // restart from DONE with a good multiplier, start held high mid-sweep
        mode4 = 0;
        kick(1);
        chk("rs_done", 32'(done4), 32'd0);
        chk("rs_busy", 32'(busy4), 32'd1);
        chk("rs_fa", 32'(fa4), 32'd0);
        chk("rs_fb", 32'(fb4), 32'd0);
        wait_done(1, 200, 100, 5000, 1, cyc);
        chk("good_lat", cyc, 32'd1537);
        chk("good_pass", 32'(pass4), 32'd1);
        chk("good_fc", 32'(fc4), 32'd0);

        // reset mid-sweep, then a fresh sweep starts from A=B=0
        kick(1);
        for (int k = 0; k < 2000 && a4 != 4'd5; k++) begin
            @(posedge clk); #1;
        end
        chk("mid_reach", 32'(a4), 32'd5);
        nrst4 = 1'b0;
        @(posedge clk); #1;
        nrst4 = 1'b1;
        chk("mid_busy", 32'(busy4), 32'd0);
        chk("mid_done", 32'(done4), 32'd0);
        chk("mid_a", 32'(a4), 32'd0);
        chk("mid_b", 32'(b4), 32'd0);
        @(posedge clk); #1;
        chk("mid_idle", 32'(busy4), 32'd0);
        kick(1);
        chk("new_busy", 32'(busy4), 32'd1);
        @(posedge clk); #1;
        chk("new_a0", 32'(a4), 32'd0);
        chk("new_b0", 32'(b4), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("new_a1", 32'(a4), 32'd0);
        chk("new_b1", 32'(b4), 32'd1);
        wait_done(1, 0, 0, 5000, 8, cyc);
        chk("new_lat", cyc, 32'd1537);
        chk("new_pass", 32'(pass4), 32'd1);

        // 20-deep delayed product with a short settle window
        nrst4 = 1'b0;
        @(posedge clk); #1;
        nrst4 = 1'b1;
        mode4 = 2;
        kick(1);
        wait_done(1, 0, 0, 5000, 1, cyc);
        chk("dly_lat", cyc, 32'd109);
        chk("dly_pass", 32'(pass4), 32'd0);
        chk("dly_fa", 32'(fa4), 32'd1);
        chk("dly_fb", 32'(fb4), 32'd1);
        chk("dly_fc", 32'(fc4), 32'd0);

        // SETTLE=12: operands step every 14 cycles
        kick(2);
        cyc = 1;
        prev_b = 0;
        nchg = 0;
        tch[0] = 0; tch[1] = 0; tch[2] = 0;
        while (nchg < 3 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (int'(b12) != prev_b) begin
                tch[nchg] = cyc;
                nchg++;
                prev_b = int'(b12);
            end
        end
        chk("s12_first", tch[0], 32'd16);
        chk("s12_gap1", tch[1] - tch[0], 32'd14);
        chk("s12_gap2", tch[2] - tch[1], 32'd14);
        wait_done(2, 0, 0, 8000, cyc, cyc);
        chk("s12_lat", cyc, 32'd3585);
        chk("s12_pass", 32'(pass12), 32'd1);

        // SETTLE=20 absorbs the 20-deep delay
        kick(3);
        wait_done(3, 0, 0, 10000, 1, cyc);
        chk("s20_lat", cyc, 32'd5633);
        chk("s20_pass", 32'(pass20), 32'd1);
        chk("s20_fc", 32'(fc20), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
